// File: rtl/lz77_pkg.sv
// Shared widths, depths and FSM encoding for the streaming LZ77 encoder.
package lz77_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned SEARCH_N   = 9;
    localparam int unsigned LOOK_N     = 8;
    localparam int unsigned POS_W      = 4;
    localparam int unsigned LEN_W      = 3;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned LOOK_IDX_W = 3;

    localparam logic [DATA_W-1:0] TERM_CHAR   = 8'h24;
    localparam logic [CNT_W-1:0]  SEARCH_FULL = CNT_W'(SEARCH_N);
    localparam logic [CNT_W-1:0]  LOOK_FULL   = CNT_W'(LOOK_N);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        FILL,
        MATCH,
        EMIT,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/lz77_match_finder.sv
// Combinational longest-match search over the search buffer, with overlap into the lookahead.
module lz77_match_finder
    import lz77_pkg::*;
(
    input  logic [DATA_W-1:0] i_search [SEARCH_N],
    input  logic [CNT_W-1:0]  i_search_cnt,
    input  logic [DATA_W-1:0] i_look   [LOOK_N],
    input  logic [CNT_W-1:0]  i_look_cnt,
    output logic [POS_W-1:0]  o_best_pos,
    output logic [LEN_W-1:0]  o_best_len
);

    localparam int unsigned STREAM_N = SEARCH_N + LOOK_N;

    // Oldest search char first, then the lookahead: the copy source for position p
    // and offset k is then simply w_stream[SEARCH_N-1-p+k], overlap included.
    logic [DATA_W-1:0] w_stream [STREAM_N];
    int unsigned       w_cap;
    int unsigned       w_scnt;
    int unsigned       w_len;
    int unsigned       w_best_p;
    int unsigned       w_best_l;
    logic              w_run;

    always_comb begin
        for (int unsigned i = 0; i < SEARCH_N; i++) begin
            w_stream[i] = i_search[SEARCH_N-1-i];
        end
        for (int unsigned m = 0; m < LOOK_N; m++) begin
            w_stream[SEARCH_N+m] = i_look[m];
        end
    end

    always_comb begin
        w_cap    = (i_look_cnt == '0) ? 0 : 32'(i_look_cnt) - 1;
        w_scnt   = 32'(i_search_cnt);
        w_best_p = 0;
        w_best_l = 0;
        w_len    = 0;
        w_run    = 1'b0;
        for (int unsigned p = 0; p < SEARCH_N; p++) begin
            w_len = 0;
            w_run = (p < w_scnt);
            for (int unsigned k = 0; k < LOOK_N - 1; k++) begin
                if (w_run && (k < w_cap) && (i_look[k] == w_stream[SEARCH_N-1-p+k])) begin
                    w_len = w_len + 1;
                end else begin
                    w_run = 1'b0;
                end
            end
            // Strict compare keeps the smallest position on ties.
            if (w_len > w_best_l) begin
                w_best_l = w_len;
                w_best_p = p;
            end
        end
        o_best_pos = POS_W'(w_best_p);
        o_best_len = LEN_W'(w_best_l);
    end

endmodule

// File: rtl/lz77_encoder.sv
// Streaming LZ77 encoder: fills a lookahead, finds the best match, emits one triple, shifts.
module lz77_encoder
    import lz77_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [POS_W-1:0]  code_pos,
    output logic [LEN_W-1:0]  code_len,
    output logic [DATA_W-1:0] char_nxt,
    output logic              encode,
    output logic              finish
);

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_search [SEARCH_N];
    logic [DATA_W-1:0] r_look   [LOOK_N];
    logic [CNT_W-1:0]  r_search_cnt;
    logic [CNT_W-1:0]  r_look_cnt;
    logic [CNT_W-1:0]  r_shift_rem;
    logic              r_term_seen;
    logic              r_encode;
    logic              r_finish;
    logic [POS_W-1:0]  r_code_pos;
    logic [LEN_W-1:0]  r_code_len;
    logic [DATA_W-1:0] r_char_nxt;
    logic [POS_W-1:0]  w_best_pos;
    logic [LEN_W-1:0]  w_best_len;
    logic              w_accept;

    lz77_match_finder u_match_finder (
        .i_search     (r_search),
        .i_search_cnt (r_search_cnt),
        .i_look       (r_look),
        .i_look_cnt   (r_look_cnt),
        .o_best_pos   (w_best_pos),
        .o_best_len   (w_best_len)
    );

    // r_encode also masks in_ready for the first cycle after reset release.
    assign in_ready  = r_encode && (r_state == FILL) && (r_look_cnt < LOOK_FULL) && !r_term_seen;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == EMIT);
    assign code_pos  = r_code_pos;
    assign code_len  = r_code_len;
    assign char_nxt  = r_char_nxt;
    assign encode    = r_encode;
    assign finish    = r_finish;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            FILL: begin
                if ((r_look_cnt == LOOK_FULL) || r_term_seen) begin
                    w_state_next = MATCH;
                end
            end
            MATCH: w_state_next = EMIT;
            EMIT: begin
                if (out_ready) begin
                    w_state_next = (r_char_nxt == TERM_CHAR) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (r_shift_rem == CNT_ONE) begin
                    w_state_next = FILL;
                end
            end
            DONE:    w_state_next = DONE;
            default: w_state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SEARCH_N; i++) begin
                r_search[i] <= '0;
            end
            for (int i = 0; i < LOOK_N; i++) begin
                r_look[i] <= '0;
            end
            r_search_cnt <= '0;
            r_look_cnt   <= '0;
            r_shift_rem  <= '0;
            r_term_seen  <= 1'b0;
            r_encode     <= 1'b0;
            r_finish     <= 1'b0;
            r_code_pos   <= '0;
            r_code_len   <= '0;
            r_char_nxt   <= '0;
        end else begin
            r_encode <= (w_state_next != DONE);
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        r_look[r_look_cnt[LOOK_IDX_W-1:0]] <= in_data;
                        r_look_cnt <= r_look_cnt + CNT_ONE;
                        if (in_data == TERM_CHAR) begin
                            r_term_seen <= 1'b1;
                        end
                    end
                end
                MATCH: begin
                    r_code_pos  <= w_best_pos;
                    r_code_len  <= w_best_len;
                    r_char_nxt  <= r_look[w_best_len];
                    r_shift_rem <= CNT_W'(w_best_len) + CNT_ONE;
                end
                EMIT: begin
                    if (out_ready && (r_char_nxt == TERM_CHAR)) begin
                        r_finish <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_search[0] <= r_look[0];
                    for (int i = 1; i < SEARCH_N; i++) begin
                        r_search[i] <= r_search[i-1];
                    end
                    for (int i = 0; i < LOOK_N - 1; i++) begin
                        r_look[i] <= r_look[i+1];
                    end
                    r_look[LOOK_N-1] <= '0;
                    r_look_cnt       <= r_look_cnt - CNT_ONE;
                    r_shift_rem      <= r_shift_rem - CNT_ONE;
                    if (r_search_cnt != SEARCH_FULL) begin
                        r_search_cnt <= r_search_cnt + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lz77_encoder.sv
// Scoreboard bench for lz77_encoder: distance-based LZ77 reference model plus decoder round trip.
module tb_lz77_encoder;
    import lz77_pkg::*;

    typedef logic [DATA_W-1:0] chr_t;
    typedef struct packed {
        logic [POS_W-1:0] pos;
        logic [LEN_W-1:0] len;
        chr_t             ch;
    } trip_t;

    logic             clk;
    logic             reset;
    logic             in_valid;
    chr_t             in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [POS_W-1:0] code_pos;
    logic [LEN_W-1:0] code_len;
    chr_t             char_nxt;
    logic             encode;
    logic             finish;

    int    checks = 0;
    int    failures = 0;
    int    n_rx = 0;
    int    stall_len = 0;
    trip_t exp_q[$];
    chr_t  dec[$];

    lz77_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .code_pos  (code_pos),
        .code_len  (code_len),
        .char_nxt  (char_nxt),
        .encode    (encode),
        .finish    (finish)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no summary expected finish within time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic trip_t mk(input int p, input int l, input chr_t c);
        trip_t t;
        t.pos = POS_W'(p);
        t.len = LEN_W'(l);
        t.ch  = c;
        return t;
    endfunction

    // Classic LZ77 over the whole string: window of the last SEARCH_N chars,
    // lookahead of the next LOOK_N chars, one literal always left over.
    function automatic void model(input chr_t s[$]);
        int i, n, lc, hc, bp, bl, l;
        i = 0;
        n = s.size();
        while (i < n) begin
            lc = (n - i < LOOK_N) ? n - i : LOOK_N;
            hc = (i < SEARCH_N) ? i : SEARCH_N;
            bp = 0;
            bl = 0;
            for (int p = 0; p < hc; p++) begin
                l = 0;
                while (l < lc - 1 && s[i+l] == s[i+l-p-1]) l++;
                if (l > bl) begin
                    bl = l;
                    bp = p;
                end
            end
            exp_q.push_back(mk(bp, bl, s[i+bl]));
            i += bl + 1;
        end
    endfunction

    // Monitor: scoreboard compare, stall-stability check and decoder model.
    initial begin
        trip_t cur, held, e;
        bit    stalled;
        int    idx;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            cur = {code_pos, code_len, char_nxt};
            if (!reset) begin
                stalled = 1'b0;
            end else begin
                if (stalled) check("stall_hold", 32'({out_valid, cur}), 32'({1'b1, held}));
                stalled = out_valid && !out_ready;
                held = cur;
                if (out_valid && out_ready) begin
                    n_rx++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_triple: got %0h expected none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        check("triple", 32'(cur), 32'(e));
                    end
                    for (int k = 0; k < int'(cur.len); k++) begin
                        idx = dec.size() - 1 - int'(cur.pos);
                        dec.push_back((idx >= 0) ? dec[idx] : 8'h00);
                    end
                    dec.push_back(cur.ch);
                end
            end
        end
    end

    // Sink: holds out_ready low for stall_len cycles at the start of every EMIT.
    initial begin
        int sc;
        sc = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                if (sc < stall_len) begin
                    out_ready = 1'b0;
                    sc++;
                end else begin
                    out_ready = 1'b1;
                end
            end else begin
                sc = 0;
                out_ready = (stall_len == 0);
            end
        end
    end

    task automatic do_reset();
        in_valid = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              32'({in_ready, out_valid, code_pos, code_len, char_nxt, encode, finish}), 32'(0));
        exp_q.delete();
        dec.delete();
        n_rx = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("encode_before_first_clock", 32'(encode), 32'(0));
        @(posedge clk);
        @(negedge clk);
        check("encode_after_first_clock", 32'(encode), 32'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input chr_t c, input int gmax);
        bit got;
        int g;
        g = (gmax > 0) ? $urandom_range(gmax, 0) : 0;
        in_valid = 1'b0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data = c;
        got = 1'b0;
        for (int t = 0; t < 500 && !got; t++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no in_ready for %0h expected accept within 500", c);
        end
    endtask

    task automatic run_q(input string name, input chr_t s[$], input trip_t fixed[$],
                         input int gmax, input int stall, input bit extra);
        bit leak, ok;
        int t;
        do_reset();
        stall_len = stall;
        if (fixed.size() != 0) exp_q = fixed;
        else model(s);
        foreach (s[i]) send(s[i], gmax);
        if (extra) begin
            in_valid = 1'b1;
            in_data = chr_t'($urandom_range(90, 65));
        end
        leak = 1'b0;
        t = 0;
        while (!finish && t < 3000) begin
            @(negedge clk);
            if (in_ready) leak = 1'b1;
            t++;
        end
        check({name, ":finish"}, 32'(finish), 32'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({name, ":done_outputs"}, 32'({encode, out_valid, in_ready, finish}), 32'(4'b0001));
        check({name, ":no_accept_after_term"}, 32'(leak), 32'(0));
        check({name, ":pending_triples"}, 32'(exp_q.size()), 32'(0));
        ok = (dec.size() == s.size());
        foreach (s[i]) if (ok && dec[i] !== s[i]) ok = 1'b0;
        check({name, ":roundtrip"}, 32'(ok), 32'(1));
    endtask

    function automatic void str2q(input string str, output chr_t q[$]);
        q.delete();
        for (int i = 0; i < str.len(); i++) q.push_back(chr_t'(str[i]));
    endfunction

    task automatic run_str(input string name, input string str, input trip_t fixed[$],
                           input int gmax, input int stall, input bit extra);
        chr_t s[$];
        str2q(str, s);
        run_q(name, s, fixed, gmax, stall, extra);
    endtask

    // Reset asserted while the first triple is being shifted out.
    task automatic reset_mid_shift();
        chr_t s[$];
        int t;
        str2q("ABCABC$", s);
        do_reset();
        stall_len = 0;
        model(s);
        foreach (s[i]) send(s[i], 0);
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (n_rx == 0 && t < 500);
        check("T6:first_triple_seen", 32'(n_rx), 32'(1));
        reset = 1'b0;
        @(negedge clk);
        check("T6:outputs_in_reset",
              32'({in_ready, out_valid, code_pos, code_len, char_nxt, encode, finish}), 32'(0));
        repeat (2) @(posedge clk);
    endtask

    initial begin
        trip_t none[$];
        trip_t e[$];
        chr_t  s[$];
        int    n;
        reset = 1'b0;
        in_valid = 1'b0;
        in_data = '0;

        e = {mk(0, 0, 8'h41), mk(0, 3, 8'h24)};
        run_str("T1", "AAAA$", e, 0, 0, 1'b0);
        e = {mk(0, 0, 8'h41), mk(0, 0, 8'h42), mk(0, 0, 8'h43), mk(2, 3, 8'h24)};
        run_str("T2", "ABCABC$", e, 0, 0, 1'b0);
        e = {mk(0, 0, 8'h41), mk(0, 7, 8'h41), mk(0, 2, 8'h24)};
        run_str("T3", "AAAAAAAAAAA$", e, 0, 0, 1'b0);
        e = {mk(0, 0, 8'h41), mk(0, 0, 8'h42), mk(1, 2, 8'h24)};
        run_str("T4", "ABAB$", e, 0, 5, 1'b0);
        e = {mk(0, 0, 8'h41), mk(0, 0, 8'h42), mk(0, 0, 8'h43), mk(2, 3, 8'h24)};
        run_str("T5", "ABCABC$", e, 3, 0, 1'b1);
        reset_mid_shift();
        run_str("T6", "ABCABC$", e, 0, 0, 1'b0);

        for (int r = 0; r < 10; r++) begin
            s.delete();
            n = $urandom_range(24, 1);
            for (int i = 0; i < n; i++) s.push_back(chr_t'(8'h41 + $urandom_range(r % 4, 0)));
            s.push_back(TERM_CHAR);
            run_q($sformatf("R%0d", r), s, none, $urandom_range(3, 0), $urandom_range(3, 0),
                  1'($urandom_range(1, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
